// File: rtl/uart_fifo_tx_if.sv
// Read-side bus between a synchronous FIFO and the UART transmitter that drains it.
// The transmitter is the master: it issues the pop strobe and consumes flag and data.
interface uart_fifo_tx_if #(
    parameter int data_width = 8
);
    logic                  fifo_empty;
    logic [data_width-1:0] fifo_rd_data;
    logic                  fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en
    );
endinterface

// File: rtl/uart_fifo_tx.sv
// UART transmitter that pops bytes from a registered-read FIFO and sends them LSB-first
// as start / data / optional parity / stop-bit frames on an idle-high serial line.
module uart_fifo_tx #(
    parameter int data_width   = 8,
    parameter int clks_per_bit = 16,
    parameter int parity_en    = 0,
    parameter int parity_odd   = 0,
    parameter int stop_bits    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_en,
    uart_fifo_tx_if.master   fifo,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done
);
    localparam int CNT_W = $clog2(clks_per_bit);
    localparam int IDX_W = (data_width > 1) ? $clog2(data_width) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(clks_per_bit - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(clks_per_bit - 2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(data_width - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(stop_bits - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t                state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_next_s;
    logic [IDX_W-1:0]      idx_r;
    logic [data_width-1:0] shift_r;
    logic                  par_r;

    function automatic logic parity_of(input logic [data_width-1:0] d);
        return (^d) ^ 1'(parity_odd);
    endfunction

    // Pop strobe is a decode of the FETCH state, suppressed while reset is asserted.
    assign fifo.fifo_rd_en = (state_r == FETCH) && !rst;

    // Baud counter successor: wraps at every bit boundary.
    always_comb begin
        if (cnt_r == CNT_LAST) begin
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + 1'b1;
        end
    end

    // Frame sequencer with registered line, busy and done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= '0;
            par_r   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_en && !fifo.fifo_empty) begin
                        state_r <= FETCH;
                        tx_busy <= 1'b1;
                    end
                end
                FETCH: begin
                    state_r <= LOAD;
                end
                LOAD: begin
                    // Parity is latched now because the shift register is consumed bit by bit.
                    shift_r <= fifo.fifo_rd_data;
                    par_r   <= parity_of(fifo.fifo_rd_data);
                    tx      <= 1'b0;
                    cnt_r   <= '0;
                    idx_r   <= '0;
                    state_r <= START;
                end
                START: begin
                    cnt_r <= cnt_next_s;
                    if (cnt_r == CNT_LAST) begin
                        tx      <= shift_r[0];
                        shift_r <= shift_r >> 1;
                        state_r <= DATA;
                    end
                end
                DATA: begin
                    cnt_r <= cnt_next_s;
                    if (cnt_r == CNT_LAST) begin
                        if (idx_r == IDX_LAST) begin
                            idx_r <= '0;
                            if (parity_en != 0) begin
                                tx      <= par_r;
                                state_r <= PARITY;
                            end else begin
                                tx      <= 1'b1;
                                state_r <= STOP;
                            end
                        end else begin
                            idx_r   <= idx_r + 1'b1;
                            tx      <= shift_r[0];
                            shift_r <= shift_r >> 1;
                        end
                    end
                end
                PARITY: begin
                    cnt_r <= cnt_next_s;
                    if (cnt_r == CNT_LAST) begin
                        tx      <= 1'b1;
                        idx_r   <= '0;
                        state_r <= STOP;
                    end
                end
                STOP: begin
                    cnt_r <= cnt_next_s;
                    // Raised one cycle early so the registered pulse lands on the final stop cycle.
                    if ((cnt_r == CNT_PRE) && (idx_r == STOP_LAST)) begin
                        tx_done <= 1'b1;
                    end
                    if (cnt_r == CNT_LAST) begin
                        if (idx_r == STOP_LAST) begin
                            idx_r   <= '0;
                            tx_busy <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            idx_r <= idx_r + 1'b1;
                        end
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: four instances (8N1, 8E1, 8O1, 8E2) fed by queue-based FIFO models,
// each frame compared cycle by cycle against a timing model built from the frame rules.
module tb_uart_fifo_tx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] en  = 4'b0000;
    logic tx0, tx1, tx2, tx3;
    logic busy0, busy1, busy2, busy3;
    logic done0, done1, done2, done3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_cnt [4];
    int done_cnt[4];

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] q3[$];

    uart_fifo_tx_if #(.data_width(8)) b0 ();
    uart_fifo_tx_if #(.data_width(8)) b1 ();
    uart_fifo_tx_if #(.data_width(8)) b2 ();
    uart_fifo_tx_if #(.data_width(8)) b3 ();

    uart_fifo_tx #(.data_width(8), .clks_per_bit(CPB), .parity_en(0), .parity_odd(0), .stop_bits(1)) dut0 (
        .clk(clk), .rst(rst), .tx_en(en[0]), .fifo(b0), .tx(tx0), .tx_busy(busy0), .tx_done(done0));
    uart_fifo_tx #(.data_width(8), .clks_per_bit(CPB), .parity_en(1), .parity_odd(0), .stop_bits(1)) dut1 (
        .clk(clk), .rst(rst), .tx_en(en[1]), .fifo(b1), .tx(tx1), .tx_busy(busy1), .tx_done(done1));
    uart_fifo_tx #(.data_width(8), .clks_per_bit(CPB), .parity_en(1), .parity_odd(1), .stop_bits(1)) dut2 (
        .clk(clk), .rst(rst), .tx_en(en[2]), .fifo(b2), .tx(tx2), .tx_busy(busy2), .tx_done(done2));
    uart_fifo_tx #(.data_width(8), .clks_per_bit(CPB), .parity_en(1), .parity_odd(0), .stop_bits(2)) dut3 (
        .clk(clk), .rst(rst), .tx_en(en[3]), .fifo(b3), .tx(tx3), .tx_busy(busy3), .tx_done(done3));

    always #5 clk = ~clk;

    assign b0.fifo_empty = (q0.size() == 0);
    assign b1.fifo_empty = (q1.size() == 0);
    assign b2.fifo_empty = (q2.size() == 0);
    assign b3.fifo_empty = (q3.size() == 0);

    // FIFO models with one-cycle registered read, plus pop and done pulse counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (b0.fifo_rd_en && q0.size() > 0) b0.fifo_rd_data <= q0.pop_front();
        if (b1.fifo_rd_en && q1.size() > 0) b1.fifo_rd_data <= q1.pop_front();
        if (b2.fifo_rd_en && q2.size() > 0) b2.fifo_rd_data <= q2.pop_front();
        if (b3.fifo_rd_en && q3.size() > 0) b3.fifo_rd_data <= q3.pop_front();
        if (b0.fifo_rd_en) pop_cnt[0] <= pop_cnt[0] + 1;
        if (b1.fifo_rd_en) pop_cnt[1] <= pop_cnt[1] + 1;
        if (b2.fifo_rd_en) pop_cnt[2] <= pop_cnt[2] + 1;
        if (b3.fifo_rd_en) pop_cnt[3] <= pop_cnt[3] + 1;
        if (done0) done_cnt[0] <= done_cnt[0] + 1;
        if (done1) done_cnt[1] <= done_cnt[1] + 1;
        if (done2) done_cnt[2] <= done_cnt[2] + 1;
        if (done3) done_cnt[3] <= done_cnt[3] + 1;
    end

    task automatic push(input int which, input logic [7:0] d);
        case (which)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic sample(input int which, output logic stx, output logic srd, output logic sbusy, output logic sdone);
        case (which)
            0: begin stx = tx0; srd = b0.fifo_rd_en; sbusy = busy0; sdone = done0; end
            1: begin stx = tx1; srd = b1.fifo_rd_en; sbusy = busy1; sdone = done1; end
            2: begin stx = tx2; srd = b2.fifo_rd_en; sbusy = busy2; sdone = done2; end
            default: begin stx = tx3; srd = b3.fifo_rd_en; sbusy = busy3; sdone = done3; end
        endcase
    endtask

    // Checks cycles t0 .. t0+3+F of one frame; t0 is the IDLE cycle with tx_en && !empty.
    task automatic check_frame(input int which, input int t0, input logic [7:0] data,
                               input int drop_k, input int exp_par, input string name);
        int pe, po, sb, f, bitn;
        logic etx, erd, ebusy, edone, stx, srd, sbusy, sdone;
        pe = (which != 0) ? 1 : 0;
        po = (which == 2) ? 1 : 0;
        sb = (which == 3) ? 2 : 1;
        f  = (1 + 8 + pe + sb) * CPB;
        for (int k = 0; k <= 3 + f; k++) begin
            while (cyc < t0 + k) @(negedge clk);
            erd   = (k == 1);
            ebusy = (k >= 1) && (k <= 2 + f);
            edone = (k == 2 + f);
            etx   = 1'b1;
            bitn  = -1;
            if (k >= 3 && k <= 2 + f) begin
                bitn = (k - 3) / CPB;
                if (bitn == 0) etx = 1'b0;
                else if (bitn <= 8) etx = data[bitn-1];
                else if (pe == 1 && bitn == 9) etx = (($countones(data) % 2) == 1) ^ (po == 1);
                else etx = 1'b1;
            end
            sample(which, stx, srd, sbusy, sdone);
            checks++;
            if (stx !== etx) begin
                errors++;
                $display("FAIL %s tx at t0+%0d: got %b want %b", name, k, stx, etx);
            end
            checks++;
            if (srd !== erd) begin
                errors++;
                $display("FAIL %s fifo_rd_en at t0+%0d: got %b want %b", name, k, srd, erd);
            end
            checks++;
            if (sbusy !== ebusy) begin
                errors++;
                $display("FAIL %s tx_busy at t0+%0d: got %b want %b", name, k, sbusy, ebusy);
            end
            checks++;
            if (sdone !== edone) begin
                errors++;
                $display("FAIL %s tx_done at t0+%0d: got %b want %b", name, k, sdone, edone);
            end
            if (exp_par >= 0 && bitn == 9 && pe == 1) begin
                checks++;
                if (stx !== exp_par[0]) begin
                    errors++;
                    $display("FAIL %s parity bit at t0+%0d: got %b want %b", name, k, stx, exp_par[0]);
                end
            end
            if (k == drop_k) en[which] = 1'b0;
        end
    endtask

    task automatic check_count(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        logic stx, srd, sbusy, sdone;
        push(0, 8'hA5);
        en[0] = 1'b1;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample(0, stx, srd, sbusy, sdone);
            checks++;
            if (stx !== 1'b1 || sbusy !== 1'b0 || srd !== 1'b0 || sdone !== 1'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: got tx=%b busy=%b rd_en=%b done=%b want 1 0 0 0",
                         i, stx, sbusy, srd, sdone);
            end
        end
        en[0] = 1'b0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        check_count("reset pop count", pop_cnt[0], 0);
        check_count("reset queue depth", q0.size(), 1);
    endtask

    task automatic test_single();
        int t0, p, d;
        p = pop_cnt[0];
        d = done_cnt[0];
        en[0] = 1'b1;
        t0 = cyc;
        check_frame(0, t0, 8'hA5, -1, -1, "single_a5");
        check_count("single pops", pop_cnt[0] - p, 1);
        check_count("single dones", done_cnt[0] - d, 1);
    endtask

    task automatic test_back_to_back();
        int t0, p, d;
        en[0] = 1'b0;
        @(negedge clk);
        p = pop_cnt[0];
        d = done_cnt[0];
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        en[0] = 1'b1;
        t0 = cyc;
        check_frame(0, t0,       8'h00, -1, -1, "b2b_0");
        check_frame(0, t0 + 163, 8'hFF, -1, -1, "b2b_1");
        check_frame(0, t0 + 326, 8'h3C, -1, -1, "b2b_2");
        check_count("b2b pops", pop_cnt[0] - p, 3);
        check_count("b2b dones", done_cnt[0] - d, 3);
    endtask

    task automatic test_flow_control();
        int t0, p;
        logic stx, srd, sbusy, sdone;
        p = pop_cnt[0];
        push(0, 8'hC3);
        push(0, 8'h96);
        t0 = cyc;
        check_frame(0, t0, 8'hC3, 3 + CPB + 40, -1, "flow_first");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sample(0, stx, srd, sbusy, sdone);
            checks++;
            if (srd !== 1'b0 || sbusy !== 1'b0) begin
                errors++;
                $display("FAIL flow paused cycle %0d: got rd_en=%b busy=%b want 0 0", i, srd, sbusy);
            end
        end
        check_count("flow paused pops", pop_cnt[0] - p, 1);
        en[0] = 1'b1;
        t0 = cyc;
        check_frame(0, t0, 8'h96, -1, -1, "flow_second");
        check_count("flow total pops", pop_cnt[0] - p, 2);
    endtask

    task automatic test_parity();
        int t0;
        en[1] = 1'b1;
        en[2] = 1'b1;
        en[3] = 1'b1;
        push(1, 8'hA5); t0 = cyc; check_frame(1, t0, 8'hA5, -1, 0, "even_a5");
        push(1, 8'h07); t0 = cyc; check_frame(1, t0, 8'h07, -1, 1, "even_07");
        push(2, 8'hA5); t0 = cyc; check_frame(2, t0, 8'hA5, -1, 1, "odd_a5");
        push(3, 8'h07); t0 = cyc; check_frame(3, t0, 8'h07, -1, 1, "stop2_07");
    endtask

    task automatic test_reset_mid_frame();
        int t0, p, d;
        logic stx, srd, sbusy, sdone;
        en[0] = 1'b1;
        p = pop_cnt[0];
        d = done_cnt[0];
        push(0, 8'h5A);
        t0 = cyc;
        while (cyc < t0 + 3 + CPB * 4 + 5) @(negedge clk);
        rst = 1'b1;
        push(0, 8'h81);
        @(negedge clk);
        sample(0, stx, srd, sbusy, sdone);
        checks++;
        if (stx !== 1'b1 || sbusy !== 1'b0 || sdone !== 1'b0) begin
            errors++;
            $display("FAIL midreset after: got tx=%b busy=%b done=%b want 1 0 0", stx, sbusy, sdone);
        end
        rst = 1'b0;
        t0 = cyc;
        check_frame(0, t0, 8'h81, -1, -1, "after_reset_81");
        check_count("midreset dones", done_cnt[0] - d, 1);
        check_count("midreset pops", pop_cnt[0] - p, 2);
    endtask

    task automatic test_random();
        int which, gap, t0;
        logic [7:0] d;
        en = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            which = int'($urandom_range(3, 0));
            gap   = int'($urandom_range(4, 0));
            d     = 8'($urandom);
            repeat (gap) @(negedge clk);
            push(which, d);
            t0 = cyc;
            check_frame(which, t0, d, -1, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flow_control();
        test_parity();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_fifo_tx.md
Name: uart_fifo_tx

Overview:
- UART transmitter that drains a synq_fifo instance. It is the read-side consumer of the buffered byte stream.
- When the FIFO is non-empty and transmission is enabled, it pops one word using the FIFO's one-cycle registered read and serialises it LSB-first.
- Frame format: start bit, data, optional parity, stop bit(s). Sits between the TX FIFO and the tx pin.

Parameters:
- data_width, 8, bits per frame; must match the FIFO data_width.
- clks_per_bit, 16, clk cycles per UART bit; minimum 2.
- parity_en, 0, 1 inserts a parity bit after the data bits.
- parity_odd, 0, 0 means even parity, 1 means odd parity; ignored when parity_en=0.
- stop_bits, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- tx_en  input  1  permits starting a new frame; a frame in progress always completes.
- fifo_empty  input  1  FIFO f_empty flag.
- fifo_rd_data  input  data_width  FIFO rd_data; valid exactly one cycle after fifo_rd_en.
- fifo_rd_en  output  1  one-cycle pop strobe to the FIFO.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  high whenever state != IDLE.
- tx_done  output  1  one-cycle pulse on the last clk of the final stop bit.

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE, tx=1, tx_done=0, baud counter=0, bit index=0, shift register=0.
  - fifo_rd_en = (state==FETCH) && !rst, so no pop occurs during a reset cycle.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If tx_en && !fifo_empty, go to FETCH; otherwise stay.
- FETCH: lasts 1 cycle, asserts fifo_rd_en, then goes to LOAD.
- LOAD:
  - Lasts 1 cycle; fifo_rd_data is valid in this cycle.
  - At the closing edge: capture fifo_rd_data into the shift register, set tx<=0, clear the baud counter, go to START.
- START: tx=0 for clks_per_bit cycles, then go to DATA with tx<=shift[0].
- DATA:
  - Each bit is held for clks_per_bit cycles. Shift right, LSB first.
  - After data_width bits, go to PARITY if parity_en, else STOP.
- PARITY:
  - tx = (^captured_data) XOR parity_odd, held for clks_per_bit cycles.
  - Even parity: total ones including the parity bit is even.
- STOP:
  - tx=1 for stop_bits*clks_per_bit cycles.
  - tx_done is high only on the final cycle. Next state is IDLE.
- tx is registered and changes only on bit boundaries; no glitches.
- Latency:
  - First IDLE cycle with tx_en && !fifo_empty = t0. tx falls at t0+3.
  - Frame length F = (1 + data_width + parity_en + stop_bits) * clks_per_bit.
  - tx_done is high at t0+2+F.
- Back-to-back frames: start-to-start spacing = F+3 cycles (IDLE, FETCH, LOAD overhead). There is exactly one fifo_rd_en pulse per frame.
- Baud counter:
  - Width $clog2(clks_per_bit); counts 0..clks_per_bit-1 and wraps at each bit boundary.
  - Bit index wraps at data_width-1.
- Flag handling:
  - fifo_empty is sampled only in IDLE. It is ignored in all other states, since no other reader exists.
  - tx_en is sampled only in IDLE.
  - tx_en falling mid-frame does not affect the current frame.
- Reset mid-operation:
  - Any state returns to IDLE, and tx=1 on the next cycle. No tx_done is generated.
  - The partially sent byte is lost. A byte already popped (reset in LOAD) is lost; this is a documented limitation.
- data_width=8 with parity_en=0 and stop_bits=1 is standard 8N1.

Test Plan:
- Reset: hold rst 3 cycles with fifo_empty=0 -> tx=1, tx_busy=0, fifo_rd_en=0 on every reset cycle; no pop.
- Single byte 0xA5 in 8N1 (clks_per_bit=16):
  - fifo_rd_en pulses once at t0+1 and tx falls at t0+3.
  - Bits 1,0,1,0,0,1,0,1 follow, each held 16 cycles, then the stop bit.
  - tx_done is a single pulse at t0+162; tx_busy falls at t0+163.
- Back-to-back 0x00, 0xFF, 0x3C preloaded:
  - Start bits at t0+3, t0+166, t0+329.
  - Exactly 3 fifo_rd_en pulses and 3 tx_done pulses.
  - Decoded bytes match in order.
- Flow control: push 2 bytes, drop tx_en during the first frame's DATA state -> first frame completes intact; no second pop. Raising tx_en pops and sends byte 2, starting 3 cycles later.
- Parity (parity_en=1):
  - parity_odd=0: 0xA5 -> parity 0; 0x07 -> parity 1.
  - parity_odd=1: 0xA5 -> parity 1.
  - Frame is 11 bits (176 cycles).
  - stop_bits=2: tx stays high 32 cycles before tx_done.
- Reset mid-DATA of 0x5A, then release with 0x81 queued -> tx=1 the cycle after reset; no tx_done for 0x5A; 0x81 is then transmitted cleanly with correct timing.
